// File: rtl/pc_seq_pkg.sv
// Shared types and defaults for the fetch-stage PC sequencer.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    NPC_SEQ = 2'b00,
    NPC_BR  = 2'b01,
    NPC_J   = 2'b10,
    NPC_JR  = 2'b11
  } npc_op_e;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_e;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] EXC_VEC_DEF  = 32'h0000_4180;

  // j/jal keep the top nibble of the PC of the jump itself.
  function automatic logic [31:0] jump_target(input logic [31:0] pc, input logic [25:0] idx);
    return {pc[31:28], idx, 2'b00};
  endfunction

endpackage

// File: rtl/pc_seq_npc.sv
// Combinational next-PC multiplexer: picks the redirect target for a decode-stage op.
module pc_seq_npc
  import pc_seq_pkg::*;
(
  input  logic [31:0] pc,
  input  npc_op_e     npc_op,
  input  logic [25:0] ins26,
  input  logic [31:0] btypc,
  input  logic [31:0] rfrs32,
  output logic [31:0] npc
);

  always_comb begin
    unique case (npc_op)
      NPC_BR:  npc = btypc;
      NPC_J:   npc = jump_target(pc, ins26);
      NPC_JR:  npc = rfrs32;
      default: npc = pc + 32'd4;
    endcase
  end

endmodule

// File: rtl/pc_seq.sv
// Fetch PC register with redirect, stall buffering and CP0 exception entry/return.
module pc_seq
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] EXC_VEC  = EXC_VEC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        id_valid,
  input  logic [31:0] id_pc,
  input  logic [1:0]  id_npc_op,
  input  logic [25:0] id_ins26,
  input  logic [31:0] id_btypc,
  input  logic [31:0] id_rfrs32,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        flush,
  output logic        pend,
  output logic        jr_misalign
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;
  state_e      state_q, state_d;
  logic        flush_q, flush_d;
  logic        jr_mis_q, jr_mis_d;

  logic [31:0] target;
  logic        redirect;
  logic        jr_bad;

  pc_seq_npc u_npc (
    .pc     (id_pc),
    .npc_op (npc_op_e'(id_npc_op)),
    .ins26  (id_ins26),
    .btypc  (id_btypc),
    .rfrs32 (id_rfrs32),
    .npc    (target)
  );

  assign redirect = id_valid && (npc_op_e'(id_npc_op) != NPC_SEQ);
  assign jr_bad   = (npc_op_e'(id_npc_op) == NPC_JR) && (target[1:0] != 2'b00);

  always_comb begin
    // NOTE: every _d gets a default first so no branch can leave it unassigned and infer a latch.
    pc_d       = pc_q;
    pend_tgt_d = pend_tgt_q;
    state_d    = state_q;
    flush_d    = 1'b0;
    jr_mis_d   = 1'b0;

    if (exc_req) begin
      pc_d       = EXC_VEC;
      pend_tgt_d = '0;
      state_d    = RUN;
      flush_d    = 1'b1;
    end else if (eret_req) begin
      pc_d       = epc;
      pend_tgt_d = '0;
      state_d    = RUN;
      flush_d    = 1'b1;
    end else if (stall) begin
      // Decode is frozen while in HOLD, so only the first request is latched.
      if (redirect && state_q == RUN) begin
        pend_tgt_d = target;
        state_d    = HOLD;
        jr_mis_d   = jr_bad;
      end
    end else if (state_q == HOLD) begin
      pc_d    = pend_tgt_q;
      state_d = RUN;
    end else if (redirect) begin
      pc_d     = target;
      jr_mis_d = jr_bad;
    end else begin
      pc_d = pc_q + 32'd4;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      pend_tgt_q <= '0;
      state_q    <= RUN;
      flush_q    <= 1'b0;
      jr_mis_q   <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      pend_tgt_q <= pend_tgt_d;
      state_q    <= state_d;
      flush_q    <= flush_d;
      jr_mis_q   <= jr_mis_d;
    end
  end

  assign pc          = pc_q;
  assign pc_plus4    = pc_q + 32'd4;
  assign flush       = flush_q;
  assign pend        = (state_q == HOLD);
  assign jr_misalign = jr_mis_q;

endmodule

// File: tb/tb_pc_seq.sv
// Self-checking bench for pc_seq: directed scenarios plus randomized traffic vs a queue-based model.
module tb_pc_seq;
  import pc_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, id_valid, exc_req, eret_req;
  logic [31:0] id_pc, id_btypc, id_rfrs32, epc;
  logic [1:0]  id_npc_op;
  logic [25:0] id_ins26;
  logic [31:0] pc, pc_plus4;
  logic        flush, pend, jr_misalign;

  int total = 0;
  int bad   = 0;

  // Reference state: buffered redirects live in a queue; it is non-empty exactly while one waits.
  logic [31:0] m_pc;
  logic [31:0] m_buf[$];
  logic        m_flush, m_jr;

  pc_seq dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .id_valid    (id_valid),
    .id_pc       (id_pc),
    .id_npc_op   (id_npc_op),
    .id_ins26    (id_ins26),
    .id_btypc    (id_btypc),
    .id_rfrs32   (id_rfrs32),
    .exc_req     (exc_req),
    .eret_req    (eret_req),
    .epc         (epc),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .flush       (flush),
    .pend        (pend),
    .jr_misalign (jr_misalign)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] ref_target();
    if (id_npc_op == 2'd1) return id_btypc;
    if (id_npc_op == 2'd2) return {id_pc[31:28], id_ins26, 2'b00};
    return id_rfrs32;
  endfunction

  function automatic logic [66:0] exp_vec();
    return {m_pc, m_pc + 32'd4, m_buf.size() != 0, m_flush, m_jr};
  endfunction

  task automatic model_reset();
    m_pc = 32'h0000_3000;
    m_buf.delete();
    m_flush = 1'b0;
    m_jr = 1'b0;
  endtask

  task automatic model_step();
    logic [31:0] tgt;
    logic        req;
    tgt = ref_target();
    req = id_valid && (id_npc_op != 2'd0);
    m_flush = 1'b0;
    m_jr = 1'b0;
    if (exc_req) begin
      m_pc = 32'h0000_4180;
      m_buf.delete();
      m_flush = 1'b1;
    end else if (eret_req) begin
      m_pc = epc;
      m_buf.delete();
      m_flush = 1'b1;
    end else if (stall) begin
      if (req && m_buf.size() == 0) begin
        m_buf.push_back(tgt);
        m_jr = (id_npc_op == 2'd3) && (tgt % 4 != 0);
      end
    end else if (m_buf.size() != 0) begin
      m_pc = m_buf.pop_front();
    end else if (req) begin
      m_pc = tgt;
      m_jr = (id_npc_op == 2'd3) && (tgt % 4 != 0);
    end else begin
      m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic idle_inputs();
    stall = 1'b0; id_valid = 1'b0; exc_req = 1'b0; eret_req = 1'b0;
    id_pc = '0; id_npc_op = 2'd0; id_ins26 = '0; id_btypc = '0; id_rfrs32 = '0; epc = '0;
  endtask

  // Advance model and DUT one clock; outputs are sampled 1 ns after the edge.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    total++;
    if ({pc, pend, flush, jr_misalign} !== {32'h0000_3000, 3'b000}) begin
      bad++;
      $display("FAIL reset_state got pc=%h pend=%b flush=%b jrm=%b want pc=00003000 pend=0 flush=0 jrm=0",
               pc, pend, flush, jr_misalign);
    end
    rst = 1'b0;
  endtask

  task automatic test_sequential();
    for (int i = 1; i <= 3; i++) begin
      tick();
      total++;
      if ({pc, flush} !== {32'h0000_3000 + 32'(4 * i), 1'b0} || {pc, pc_plus4, pend, flush, jr_misalign} !== exp_vec()) begin
        bad++;
        $display("FAIL seq_step%0d got pc=%h flush=%b want pc=%h flush=0", i, pc, flush, 32'h0000_3000 + 32'(4 * i));
      end
    end
  endtask

  task automatic test_jump();
    id_valid = 1'b1; id_pc = 32'h0000_3008; id_npc_op = 2'd2; id_ins26 = 26'h0000C10;
    tick();
    total++;
    if (pc !== 32'h0000_3040 || flush !== 1'b0) begin
      bad++;
      $display("FAIL jump_target got pc=%h flush=%b want pc=00003040 flush=0", pc, flush);
    end
    idle_inputs();
    tick();
    total++;
    if (pc !== 32'h0000_3044) begin
      bad++;
      $display("FAIL jump_next got pc=%h want pc=00003044", pc);
    end
  endtask

  task automatic test_stall_branch();
    logic [31:0] held;
    held = pc;
    id_valid = 1'b1; id_npc_op = 2'd1; id_btypc = 32'h0000_3100; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (pc !== held || pend !== 1'b1 || {pc, pc_plus4, pend, flush, jr_misalign} !== exp_vec()) begin
        bad++;
        $display("FAIL stall_hold%0d got pc=%h pend=%b want pc=%h pend=1", i, pc, pend, held);
      end
    end
    stall = 1'b0;
    tick();
    total++;
    if (pc !== 32'h0000_3100 || pend !== 1'b0) begin
      bad++;
      $display("FAIL stall_apply got pc=%h pend=%b want pc=00003100 pend=0", pc, pend);
    end
    idle_inputs();
    tick();
    total++;
    if (pc !== 32'h0000_3104 || pend !== 1'b0) begin
      bad++;
      $display("FAIL stall_no_double got pc=%h pend=%b want pc=00003104 pend=0", pc, pend);
    end
  endtask

  task automatic test_exc_in_hold();
    id_valid = 1'b1; id_npc_op = 2'd3; id_rfrs32 = 32'h0000_3200; stall = 1'b1;
    tick();
    exc_req = 1'b1;
    tick();
    total++;
    if (pc !== 32'h0000_4180 || flush !== 1'b1 || pend !== 1'b0) begin
      bad++;
      $display("FAIL exc_hold got pc=%h flush=%b pend=%b want pc=00004180 flush=1 pend=0", pc, flush, pend);
    end
    exc_req = 1'b0; id_valid = 1'b0;
    tick();
    total++;
    if (flush !== 1'b0 || pc !== 32'h0000_4180) begin
      bad++;
      $display("FAIL exc_flush_pulse got pc=%h flush=%b want pc=00004180 flush=0", pc, flush);
    end
    stall = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (pc === 32'h0000_3200 || {pc, pc_plus4, pend, flush, jr_misalign} !== exp_vec()) begin
        bad++;
        $display("FAIL exc_discard%0d got pc=%h want pc=%h", i, pc, m_pc);
      end
    end
  endtask

  task automatic test_jr_misalign();
    id_valid = 1'b1; id_npc_op = 2'd3; id_rfrs32 = 32'h0000_3202;
    tick();
    total++;
    if (pc !== 32'h0000_3202 || jr_misalign !== 1'b1) begin
      bad++;
      $display("FAIL jr_mis_set got pc=%h jrm=%b want pc=00003202 jrm=1", pc, jr_misalign);
    end
    idle_inputs();
    tick();
    total++;
    if (pc !== 32'h0000_3206 || jr_misalign !== 1'b0) begin
      bad++;
      $display("FAIL jr_mis_pulse got pc=%h jrm=%b want pc=00003206 jrm=0", pc, jr_misalign);
    end
  endtask

  task automatic test_exc_eret();
    exc_req = 1'b1; eret_req = 1'b1; epc = 32'h0000_3010;
    tick();
    total++;
    if (pc !== 32'h0000_4180 || flush !== 1'b1) begin
      bad++;
      $display("FAIL exc_over_eret got pc=%h flush=%b want pc=00004180 flush=1", pc, flush);
    end
    exc_req = 1'b0;
    tick();
    total++;
    if (pc !== 32'h0000_3010 || flush !== 1'b1) begin
      bad++;
      $display("FAIL eret got pc=%h flush=%b want pc=00003010 flush=1", pc, flush);
    end
    idle_inputs();
    tick();
    total++;
    if (pc !== 32'h0000_3014 || flush !== 1'b0) begin
      bad++;
      $display("FAIL eret_after got pc=%h flush=%b want pc=00003014 flush=0", pc, flush);
    end
  endtask

  task automatic test_wrap();
    id_valid = 1'b1; id_npc_op = 2'd3; id_rfrs32 = 32'hFFFF_FFFC;
    tick();
    total++;
    if (pc !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0000_0000) begin
      bad++;
      $display("FAIL wrap_plus4 got pc=%h p4=%h want pc=fffffffc p4=00000000", pc, pc_plus4);
    end
    idle_inputs();
    tick();
    total++;
    if (pc !== 32'h0000_0000) begin
      bad++;
      $display("FAIL wrap_seq got pc=%h want pc=00000000", pc);
    end
  endtask

  task automatic test_async_reset();
    id_valid = 1'b1; id_npc_op = 2'd1; id_btypc = 32'h0000_5000; stall = 1'b1;
    tick();
    total++;
    if (pend !== 1'b1) begin
      bad++;
      $display("FAIL areset_enter_hold got pend=%b want pend=1", pend);
    end
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    total++;
    if (pc !== 32'h0000_3000 || pend !== 1'b0) begin
      bad++;
      $display("FAIL areset_immediate got pc=%h pend=%b want pc=00003000 pend=0", pc, pend);
    end
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
    tick();
    total++;
    if (pc !== 32'h0000_3004 || pend !== 1'b0) begin
      bad++;
      $display("FAIL areset_discard got pc=%h pend=%b want pc=00003004 pend=0", pc, pend);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      stall     = ($urandom_range(0, 9) < 3);
      id_valid  = ($urandom_range(0, 3) != 0);
      id_npc_op = 2'($urandom_range(0, 3));
      id_pc     = $urandom;
      id_ins26  = 26'($urandom);
      id_btypc  = $urandom;
      id_rfrs32 = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      exc_req   = ($urandom_range(0, 19) == 0);
      eret_req  = ($urandom_range(0, 19) == 0);
      epc       = $urandom;
      tick();
      total++;
      if ({pc, pc_plus4, pend, flush, jr_misalign} !== exp_vec()) begin
        bad++;
        $display("FAIL random%0d got=%h want=%h", i, {pc, pc_plus4, pend, flush, jr_misalign}, exp_vec());
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_jump();
    test_stall_branch();
    test_exc_in_hold();
    test_jr_misalign();
    test_exc_eret();
    test_wrap();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
